// File: rtl/keccak_state_streamer.sv
// -----------------------------------------------------------------------------
// keccak_state_streamer
//
// Moves a Keccak state between its 5x5-lane array form and the bitstring form.
// The bitstring goes out or comes in as a stream of one lane per beat. Lane
// A[x][y] sits at flat bits [W*(5y+x) +: W]. Beat n carries lane n, and bit z
// of the lane is data bit z.
//
//   mode_i = 0 (pack)  : state_i is captured on start. The 25 lanes are then
//                        driven out on out_valid_o/out_ready_i/out_data_o.
//   mode_i = 1 (unpack): 25 lanes are accepted on in_valid_i/in_ready_o/
//                        in_data_i. Each accepted lane is written into state_o.
//
// Ports
//   clk, reset          : rising-edge clock; asynchronous active-high reset
//   mode_i, start_i     : operation select and start (honoured in IDLE only)
//   state_i / state_o   : flat 25*W state arrays (input to pack, result of unpack)
//   in_valid_i, in_ready_o, in_data_i    : unpack stream (sink)
//   out_valid_o, out_ready_i, out_data_o : pack stream (source)
//   busy_o              : high while packing or unpacking
//   done_o              : one-cycle pulse after the 25th beat
//
// Optional feature: define STATE_STREAMER_ABORT_EN to add input abort_i.
// When abort_i is high during pack or unpack, the block returns to IDLE on the
// next cycle. No done_o is raised, and lanes already written to state_o are kept.
// -----------------------------------------------------------------------------
module keccak_state_streamer #(
  parameter int W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode_i,
  input  logic            start_i,
  input  logic [25*W-1:0] state_i,
  output logic [25*W-1:0] state_o,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [W-1:0]    in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [W-1:0]    out_data_o,
  output logic            busy_o,
`ifdef STATE_STREAMER_ABORT_EN
  output logic            done_o,
  input  logic            abort_i
`else
  output logic            done_o
`endif
);

  typedef enum logic [1:0] {IDLE, PACK, UNPACK, DONE} fsm_t;

  fsm_t            fsm;
  logic [4:0]      lane_cnt;
  logic [25*W-1:0] shadow;
  logic [4:0]      lane_nxt;
  logic            last_lane;
  logic            abort;

`ifdef STATE_STREAMER_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // The lane counter stops at 24. The next-lane index is clamped so the
  // shadow lane select never points past lane 24.
  assign last_lane = (lane_cnt == 5'd24);
  assign lane_nxt  = last_lane ? 5'd0 : lane_cnt + 5'd1;

  // NOTE: all state below uses non-blocking assignments, so every branch
  // reads the values from before the edge, whatever order the branches run in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the wide shadow and state_o registers are reset on purpose.
      // A reset must wipe any partially unpacked state.
      fsm         <= IDLE;
      lane_cnt    <= '0;
      shadow      <= '0;
      state_o     <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (start_i) begin
            lane_cnt <= '0;
            busy_o   <= 1'b1;
            if (!mode_i) begin
              // Pack works from a snapshot, so later state_i changes cannot
              // disturb the stream. Lane 0 is presented right away.
              shadow      <= state_i;
              out_data_o  <= state_i[W-1:0];
              out_valid_o <= 1'b1;
              fsm         <= PACK;
            end else begin
              in_ready_o <= 1'b1;
              fsm        <= UNPACK;
            end
          end
        end

        PACK: begin
          if (abort) begin
            fsm         <= IDLE;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            busy_o      <= 1'b0;
          end else if (out_ready_i) begin
            if (last_lane) begin
              fsm         <= DONE;
              out_valid_o <= 1'b0;
              out_data_o  <= '0;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              // out_data_o changes only on a transfer, so it holds steady
              // while the sink stalls.
              lane_cnt   <= lane_nxt;
              out_data_o <= shadow[W*lane_nxt +: W];
            end
          end
        end

        UNPACK: begin
          if (abort) begin
            fsm        <= IDLE;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b0;
          end else if (in_valid_i) begin
            state_o[W*lane_cnt +: W] <= in_data_i;
            if (last_lane) begin
              fsm        <= DONE;
              in_ready_o <= 1'b0;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
            end else begin
              lane_cnt <= lane_nxt;
            end
          end
        end

        DONE: fsm <= IDLE;

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_state_streamer.sv
// -----------------------------------------------------------------------------
// tb_keccak_state_streamer
//
// Testbench for keccak_state_streamer. It instantiates two copies of the block:
// a W=64 instance for the pack and unpack sequences, and a W=8 instance for the
// narrow-lane unpack case.
//
// The reference model describes what the stream means, not how the block is
// built. Beat n of a pack must equal lane n of the submitted state. After an
// unpack, lane n of state_o must equal the n-th accepted beat, and all other
// lanes keep their previous contents.
// -----------------------------------------------------------------------------
module tb_keccak_state_streamer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- W = 64 instance ----------------
  logic          mode, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [1599:0] state_in, state_out;
  logic [63:0]   in_data, out_data;
`ifdef STATE_STREAMER_ABORT_EN
  logic          abort;
`endif

  keccak_state_streamer #(.W(64)) u_dut64 (
    .clk        (clk),
    .reset      (reset),
    .mode_i     (mode),
    .start_i    (start),
    .state_i    (state_in),
    .state_o    (state_out),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .busy_o     (busy),
`ifdef STATE_STREAMER_ABORT_EN
    .done_o     (done),
    .abort_i    (abort)
`else
    .done_o     (done)
`endif
  );

  // ---------------- W = 8 instance ----------------
  logic         mode8, start8, in_valid8, in_ready8, out_valid8, out_ready8, busy8, done8;
  logic [199:0] state_in8, state_out8;
  logic [7:0]   in_data8, out_data8;
`ifdef STATE_STREAMER_ABORT_EN
  logic         abort8;
`endif

  keccak_state_streamer #(.W(8)) u_dut8 (
    .clk        (clk),
    .reset      (reset),
    .mode_i     (mode8),
    .start_i    (start8),
    .state_i    (state_in8),
    .state_o    (state_out8),
    .in_valid_i (in_valid8),
    .in_ready_o (in_ready8),
    .in_data_i  (in_data8),
    .out_valid_o(out_valid8),
    .out_ready_i(out_ready8),
    .out_data_o (out_data8),
    .busy_o     (busy8),
`ifdef STATE_STREAMER_ABORT_EN
    .done_o     (done8),
    .abort_i    (abort8)
`else
    .done_o     (done8)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Expected contents of the W=64 state_o. The value carries over between
  // operations, because starting an unpack must not clear state_o.
  logic [1599:0] model_state;

  task automatic check(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1599:0] random_state();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Runs one full pack operation on the W=64 instance.
  // The sink may stall at random (rnd_ready), or on one chosen beat for a
  // fixed number of cycles (stall_beat/stall_len).
  task automatic run_pack(input logic [1599:0] st, input bit rnd_ready,
                          input int stall_beat, input int stall_len,
                          output logic [1599:0] got_flat, output int cyc);
    int got;
    int stall_left;
    got        = 0;
    stall_left = stall_len;
    got_flat   = '0;
    cyc        = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; state_in = st;
    @(posedge clk); #1;
    start = 1'b0; state_in = ~st;
    while (got < 25 && cyc < 400) begin
      if (got == stall_beat && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start = 1'($urandom_range(0, 1));
      mode  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("pack_flags", {busy, out_valid, in_ready, done}, 4'b1100);
      check("pack_lane", out_data, st[64*got +: 64]);
      if (out_ready) begin
        got_flat[64*got +: 64] = out_data;
        got++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    check("pack_beat_count", got, 25);
    out_ready = 1'b1; start = 1'b1; mode = 1'b0;
    @(negedge clk);
    check("pack_done_pulse", {busy, out_valid, done}, 3'b001);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("pack_back_idle", {busy, out_valid, done}, 3'b000);
  endtask

  // Runs one unpack operation on the W=64 instance.
  // vmode selects the valid pattern: 0 = always valid, 1 = every other cycle,
  // 2 = random. When reset_at >= 0, reset is asserted on that beat.
  task automatic run_unpack(input logic [1599:0] beats, input int vmode, input int reset_at);
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (acc < 25 && cyc < 400) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? beats[64*acc +: 64] : {$urandom, $urandom};
      start   = 1'($urandom_range(0, 1));
      mode    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("unpack_flags", {busy, in_ready, out_valid, done}, 4'b1100);
      check("unpack_state", state_out, model_state);
      if (acc == reset_at) begin
        reset = 1'b1;
        #1;
        check("reset_state_o", state_out, '0);
        check("reset_flags", {out_data, out_valid, in_ready, busy, done}, '0);
        model_state = '0;
        in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      if (in_valid) begin
        model_state[64*acc +: 64] = beats[64*acc +: 64];
        acc++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    check("unpack_beat_count", acc, 25);
    in_valid = 1'b0; start = 1'b1; mode = 1'b1;
    @(negedge clk);
    check("unpack_done_pulse", {busy, in_ready, done}, 3'b001);
    check("unpack_final_state", state_out, model_state);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("unpack_back_idle", {busy, in_ready, done}, 3'b000);
    check("unpack_state_held", state_out, model_state);
  endtask

  typedef struct {
    string         name;
    logic [1599:0] st;
    int            lane_a;
    logic [63:0]   exp_a;
    int            lane_b;
    logic [63:0]   exp_b;
  } pack_vec_t;

  initial begin
    pack_vec_t     tbl[3];
    logic [1599:0] st;
    logic [1599:0] got_flat;
    int            cyc;
    logic [199:0]  exp8;
    int            acc8;
    int            cyc8;

    reset = 1'b1;
    mode = 1'b0; start = 1'b0; state_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mode8 = 1'b0; start8 = 1'b0; state_in8 = '0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
`ifdef STATE_STREAMER_ABORT_EN
    abort = 1'b0; abort8 = 1'b0;
`endif
    model_state = '0;

    #3;
    check("reset_state64", state_out, '0);
    check("reset_outs64", {out_data, out_valid, in_ready, busy, done}, '0);
    check("reset_outs8", {state_out8, out_data8, out_valid8, in_ready8, busy8, done8}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Table of pack vectors. Each entry gives a state and the expected value
    // of two probe beats.
    tbl[0].name = "single_bit_a000";
    tbl[0].st = '0; tbl[0].st[0] = 1'b1;
    tbl[0].lane_a = 0;  tbl[0].exp_a = 64'h0000_0000_0000_0001;
    tbl[0].lane_b = 24; tbl[0].exp_b = 64'h0;

    tbl[1].name = "lanes_1_and_5";
    tbl[1].st = '0;
    tbl[1].st[64*1 +: 64] = 64'hAAAA_AAAA_AAAA_AAAA;
    tbl[1].st[64*5 +: 64] = 64'h5555_5555_5555_5555;
    tbl[1].lane_a = 1; tbl[1].exp_a = 64'hAAAA_AAAA_AAAA_AAAA;
    tbl[1].lane_b = 5; tbl[1].exp_b = 64'h5555_5555_5555_5555;

    tbl[2].name = "top_lane_only";
    tbl[2].st = '0;
    tbl[2].st[64*24 +: 64] = 64'hDEAD_BEEF_0123_4567;
    tbl[2].lane_a = 24; tbl[2].exp_a = 64'hDEAD_BEEF_0123_4567;
    tbl[2].lane_b = 23; tbl[2].exp_b = 64'h0;

    for (int i = 0; i < 3; i++) begin
      run_pack(tbl[i].st, 1'b0, -1, 0, got_flat, cyc);
      check({tbl[i].name, "_probe_a"}, got_flat[64*tbl[i].lane_a +: 64], tbl[i].exp_a);
      check({tbl[i].name, "_probe_b"}, got_flat[64*tbl[i].lane_b +: 64], tbl[i].exp_b);
      check({tbl[i].name, "_all_beats"}, got_flat, tbl[i].st);
      check({tbl[i].name, "_cycles"}, cyc, 25);
    end

    // Three-cycle sink stall on beat 7: the data must hold and no beat may be
    // skipped or repeated.
    st = random_state();
    run_pack(st, 1'b0, 7, 3, got_flat, cyc);
    check("stall7_beats", got_flat, st);
    check("stall7_cycles", cyc, 28);

    // Random backpressure.
    for (int i = 0; i < 3; i++) begin
      st = random_state();
      run_pack(st, 1'b1, -1, 0, got_flat, cyc);
      check("rnd_ready_beats", got_flat, st);
    end

    // Unpack with full-rate, alternating and random valid patterns.
    run_unpack(random_state(), 0, -1);
    run_unpack(random_state(), 1, -1);
    run_unpack(random_state(), 2, -1);

    // Reset on beat 12 of an unpack, then a full operation afterwards.
    run_unpack(random_state(), 0, 12);
    run_unpack(random_state(), 2, -1);

    // W=8 unpack: beat n carries value n, and valid toggles every other cycle.
    for (int n = 0; n < 25; n++) exp8[8*n +: 8] = 8'(n);
    acc8 = 0;
    cyc8 = 0;
    @(posedge clk); #1;
    start8 = 1'b1; mode8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    while (acc8 < 25 && cyc8 < 100) begin
      in_valid8 = (cyc8 % 2 == 0);
      in_data8  = in_valid8 ? 8'(acc8) : 8'hFF;
      @(negedge clk);
      check("w8_no_early_done", {done8, in_ready8}, 2'b01);
      if (in_valid8) acc8++;
      cyc8++;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    check("w8_beat_count", acc8, 25);
    @(negedge clk);
    check("w8_done_pulse", done8, 1'b1);
    check("w8_state", state_out8, exp8);
    @(negedge clk);
    check("w8_done_single", done8, 1'b0);

`ifdef STATE_STREAMER_ABORT_EN
    // Abort on beat 10 of a pack; a new start must then be accepted.
    st = random_state();
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; state_in = st;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_at_beat10", out_data, st[64*10 +: 64]);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {out_valid, busy, done}, 3'b000);
    @(negedge clk);
    check("abort_no_done", {out_valid, busy, done}, 3'b000);
    st = random_state();
    run_pack(st, 1'b0, -1, 0, got_flat, cyc);
    check("abort_restart_beats", got_flat, st);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keccak_state_streamer.md
KECCAK_STATE_STREAMER -- requirements
Module: keccak_state_streamer

Interface
REQ-001 The block SHALL have parameter W, default 64, Keccak lane width (legal 1,2,4,8,16,32,64); state size b = 25*W.
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port mode_i  input  1  0 = pack (state array -> bitstring stream), 1 = unpack (stream -> state array); sampled with start_i.
REQ-005 The block SHALL have port start_i  input  1  begin operation; honoured in IDLE only.
REQ-006 The block SHALL have port state_i  input  25*W  flat state array; lane A[x][y] at bits [W*(5y+x) +: W].
REQ-007 The block SHALL have port state_o  output  25*W  unpacked state array, same lane layout.
REQ-008 The block SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1), in_data_i (input, W): unpack stream, one lane per beat.
REQ-009 The block SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, W): pack stream, one lane per beat.
REQ-010 The block SHALL have ports busy_o (output, 1), high in PACK/UNPACK, and done_o (output, 1), one-cycle completion pulse.

Function
REQ-011 Bitstring bit W*(5y+x)+z SHALL equal A[x][y][z]; beat n (0..24) SHALL carry lane n = 5y+x, bit z at data bit z.
REQ-012 FSM states SHALL be IDLE, PACK, UNPACK, DONE.
REQ-013 IDLE, start_i=1, mode_i=0 SHALL capture state_i into an internal shadow register, clear lane counter, enter PACK next cycle.
REQ-014 IDLE, start_i=1, mode_i=1 SHALL clear lane counter and enter UNPACK next cycle; state_o not cleared.
REQ-015 PACK: out_valid_o=1, out_data_o = shadow lane[counter]; out_data_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-016 A beat transfers when valid and ready are both 1 on a rising edge; counter SHALL then increment.
REQ-017 UNPACK: in_ready_o=1; accepted in_data_i SHALL be written to state_o lane[counter] at that edge; other lanes held.
REQ-018 Transfer of beat 24 SHALL move FSM to DONE; counter SHALL not wrap past 24.
REQ-019 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-020 out_valid_o SHALL be 0 outside PACK; in_ready_o SHALL be 0 outside UNPACK.
REQ-021 start_i outside IDLE (including DONE) SHALL be ignored; state_i changes after capture SHALL not affect output.
REQ-022 Throughput SHALL be one beat per cycle with continuous handshake; operation = 25 beat cycles + 1 DONE cycle.

Reset
REQ-023 reset=1 SHALL asynchronously force IDLE, counter 0, shadow 0, state_o 0, out_data_o 0, out_valid_o, in_ready_o, busy_o, done_o all 0.
REQ-024 Reset mid-operation SHALL abandon the transfer; partial state_o contents SHALL be cleared; no done_o.

Configuration
REQ-025 Macro STATE_STREAMER_ABORT_EN defined SHALL add input abort_i (1 bit): high in PACK/UNPACK returns FSM to IDLE next cycle, no done_o, state_o holds lanes already written.
REQ-026 Macro undefined SHALL omit abort_i entirely; operations run to completion or reset.

Verification
REQ-027 W=64, pack, state_i with only A[0][0][0]=1, out_ready_i=1 -> beat 0 = 0x0000000000000001, beats 1..24 = 0, done_o pulse at cycle 26.
REQ-028 W=64, pack, A[1][0]=0xAAAA..AA, A[0][1]=0x5555..55 -> beat 1 = 0xAA..AA, beat 5 = 0x55..55, others 0.
REQ-029 W=8, unpack, beats n supplied as value n with in_valid_i toggling every other cycle -> state_o lane n = n, done_o after 25th accepted beat only.
REQ-030 Pack with out_ready_i=0 for 3 cycles on beat 7 -> out_data_o stable for those cycles, no beat skipped or repeated.
REQ-031 reset=1 asserted on beat 12 of unpack -> all outputs 0 immediately; next start runs a full 25 beats.
REQ-032 With STATE_STREAMER_ABORT_EN, abort_i at beat 10 of pack -> IDLE next cycle, out_valid_o=0, no done_o; start_i then accepted.
